// File: rtl/numeric_entry.sv
// -----------------------------------------------------------------------------
// numeric_entry
//   Collects a decimal number typed on a PS/2 keyboard. Digits shift in from
//   the right into a small BCD buffer, BACKSPACE removes the last digit, CLEAR
//   empties the buffer, and ENTER commits the buffer to Value if it lies inside
//   [MIN_VAL, MAX_VAL]. Release (F0-prefixed) and extended (E0) bytes are
//   filtered so only make codes act as keystrokes.
//
// Ports
//   Clock        rising-edge system clock
//   nReset       asynchronous active-low reset
//   Enable       editing allowed when high; low forces IDLE and holds contents
//   data         PS/2 scan-code byte
//   data_en      one-cycle strobe qualifying data
//   Value        last committed value (registered)
//   value_valid  one-cycle pulse per successful commit
//   err          one-cycle pulse per rejected keystroke
//   live_bcd     entry buffer as BCD, least significant digit in [3:0]
//   count        number of digits currently in the buffer
//   editing      high while in ENTRY (exposes the FSM state)
//
// Handshake: data is sampled on every rising edge where data_en is high; there
// is no back-pressure, every strobe is consumed. Results (Value, value_valid,
// err, buffer) appear one cycle after the accepting edge.
// -----------------------------------------------------------------------------
module numeric_entry #(
   parameter int DIGITS  = 3,
   parameter int VAL_W   = 10,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 999
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  Enable,
   input  logic [7:0]            data,
   input  logic                  data_en,
   output logic [VAL_W-1:0]      Value,
   output logic                  value_valid,
   output logic                  err,
   output logic [4*DIGITS-1:0]   live_bcd,
   output logic [2:0]            count,
   output logic                  editing
);

   localparam logic [7:0] K_ENTER   = 8'h24;
   localparam logic [7:0] K_BACK    = 8'h2D;
   localparam logic [7:0] K_CLEAR   = 8'h15;
   localparam logic [7:0] K_RELEASE = 8'hF0;
   localparam logic [7:0] K_EXTEND  = 8'hE0;

   // The live value is formed at a width that holds any buffer content
   // (99999 needs 17 bits), so an over-range buffer is never truncated
   // before the range check, even when VAL_W only covers MAX_VAL.
   localparam int WIDE_W = (VAL_W > 17) ? VAL_W : 17;
   localparam int WS     = WIDE_W + 1;

   typedef enum logic {IDLE, ENTRY} state_t;

   state_t                 state_q;
   logic                   break_q;
   logic [DIGITS-1:0][3:0] digits_q;
   logic [2:0]             count_q;
   logic [VAL_W-1:0]       value_q;
   logic                   valid_q;
   logic                   err_q;

   logic                   is_digit;
   logic [3:0]             key_digit;
   logic                   accept;
   logic [WIDE_W-1:0]      live_wide;
   logic signed [WS-1:0]   live_s;
   logic                   in_range;

   // Scan-code to digit decode.
   always_comb begin
      is_digit  = 1'b1;
      key_digit = 4'd0;
      case (data)
         8'h45:   key_digit = 4'd0;
         8'h16:   key_digit = 4'd1;
         8'h1E:   key_digit = 4'd2;
         8'h26:   key_digit = 4'd3;
         8'h25:   key_digit = 4'd4;
         8'h2E:   key_digit = 4'd5;
         8'h36:   key_digit = 4'd6;
         8'h3D:   key_digit = 4'd7;
         8'h3E:   key_digit = 4'd8;
         8'h46:   key_digit = 4'd9;
         default: is_digit  = 1'b0;
      endcase
   end

   // A byte following F0 is the release of a key and must not act.
   assign accept = data_en && Enable && !break_q &&
                   (data != K_RELEASE) && (data != K_EXTEND);

   // Horner evaluation, most significant digit first.
   always_comb begin
      live_wide = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         live_wide = (live_wide * WIDE_W'(10)) + WIDE_W'(digits_q[i]);
      end
   end

   // Signed compare avoids a constant-true test when MIN_VAL is 0.
   assign live_s   = $signed({1'b0, live_wide});
   assign in_range = (live_s >= $signed(WS'(MIN_VAL))) &&
                     (live_s <= $signed(WS'(MAX_VAL)));

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= IDLE;
         break_q  <= 1'b0;
         digits_q <= '0;
         count_q  <= 3'd0;
         value_q  <= VAL_W'(MIN_VAL);
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;

         // Break tracking runs on every strobe, independent of Enable.
         if (data_en) begin
            if (data == K_RELEASE)     break_q <= 1'b1;
            else if (data != K_EXTEND) break_q <= 1'b0;
         end

         if (!Enable) begin
            state_q <= IDLE;
         end else if (accept) begin
            if (is_digit) begin
               if (state_q == IDLE) begin
                  digits_q    <= '0;
                  digits_q[0] <= key_digit;
                  count_q     <= 3'd1;
                  state_q     <= ENTRY;
               end else if (count_q < 3'(DIGITS)) begin
                  for (int i = DIGITS - 1; i >= 1; i--) begin
                     digits_q[i] <= digits_q[i-1];
                  end
                  digits_q[0] <= key_digit;
                  count_q     <= count_q + 3'd1;
               end else begin
                  err_q <= 1'b1;
               end
            end else begin
               case (data)
                  K_ENTER: begin
                     if (state_q == ENTRY) begin
                        if (in_range) begin
                           value_q <= live_wide[VAL_W-1:0];
                           valid_q <= 1'b1;
                           state_q <= IDLE;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                  end
                  K_BACK: begin
                     if (state_q == ENTRY) begin
                        for (int i = 0; i < DIGITS - 1; i++) begin
                           digits_q[i] <= digits_q[i+1];
                        end
                        digits_q[DIGITS-1] <= 4'd0;
                        count_q            <= count_q - 3'd1;
                        if (count_q == 3'd1) state_q <= IDLE;
                     end
                  end
                  K_CLEAR: begin
                     digits_q <= '0;
                     count_q  <= 3'd0;
                     state_q  <= IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign Value       = value_q;
   assign value_valid = valid_q;
   assign err         = err_q;
   assign live_bcd    = digits_q;
   assign count       = count_q;
   assign editing     = (state_q == ENTRY);

endmodule

// File: tb/tb_numeric_entry.sv
// -----------------------------------------------------------------------------
// tb_numeric_entry
//   Drives two numeric_entry instances with the same byte stream: one with the
//   default parameters and one with a narrow accepted range [5, 99]. A model
//   holds each buffer as a plain integer plus a digit count and predicts every
//   output after each byte.
// -----------------------------------------------------------------------------
module tb_numeric_entry;

   localparam int TB_DIGITS = 3;

   localparam logic [7:0] K_ENTER = 8'h24;
   localparam logic [7:0] K_BACK  = 8'h2D;
   localparam logic [7:0] K_CLEAR = 8'h15;
   localparam logic [7:0] K_F0    = 8'hF0;
   localparam logic [7:0] K_E0    = 8'hE0;

   // ---------------------------------------------------------------- clock/reset
   logic        Clock;
   logic        nReset;
   logic        Enable;
   logic [7:0]  data;
   logic        data_en;

   logic [9:0]  value0;
   logic        vv0, err0, ed0;
   logic [11:0] bcd0;
   logic [2:0]  cnt0;

   logic [6:0]  value1;
   logic        vv1, err1, ed1;
   logic [11:0] bcd1;
   logic [2:0]  cnt1;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   numeric_entry #(.DIGITS(3), .VAL_W(10), .MIN_VAL(0), .MAX_VAL(999)) dut0 (
      .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data),
      .data_en(data_en), .Value(value0), .value_valid(vv0), .err(err0),
      .live_bcd(bcd0), .count(cnt0), .editing(ed0));

   numeric_entry #(.DIGITS(3), .VAL_W(7), .MIN_VAL(5), .MAX_VAL(99)) dut1 (
      .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data),
      .data_en(data_en), .Value(value1), .value_valid(vv1), .err(err1),
      .live_bcd(bcd1), .count(cnt1), .editing(ed1));

   // ---------------------------------------------------------------- model
   int  m_num[2];
   int  m_cnt[2];
   int  m_val[2];
   bit  m_entry[2];
   bit  m_brk[2];
   bit  m_vv[2];
   bit  m_err[2];

   logic [9:0] exp_q[$];     // commits expected from dut0, in order

   int n_checks;
   int n_fail;
   int vv_seen[2];
   int err_seen[2];

   function automatic int min_of(input int k);
      return (k == 0) ? 0 : 5;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? 999 : 99;
   endfunction

   function automatic int digit_of(input logic [7:0] b);
      case (b)
         8'h45: return 0;
         8'h16: return 1;
         8'h1E: return 2;
         8'h26: return 3;
         8'h25: return 4;
         8'h2E: return 5;
         8'h36: return 6;
         8'h3D: return 7;
         8'h3E: return 8;
         8'h46: return 9;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] code_of(input int d);
      logic [7:0] codes [10];
      codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      return codes[d];
   endfunction

   function automatic logic [31:0] bcd_of(input int num);
      logic [31:0] r;
      int          n;
      r = '0;
      n = num;
      for (int i = 0; i < TB_DIGITS; i++) begin
         r = r | (32'(n % 10) << (4 * i));
         n = n / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_num[k] = 0;  m_cnt[k] = 0;  m_val[k] = min_of(k);
         m_entry[k] = 0; m_brk[k] = 0; m_vv[k] = 0; m_err[k] = 0;
      end
      exp_q.delete();
   endtask

   task automatic model_step(input int k, input logic [7:0] b, input logic en);
      bit prev;
      int d;
      m_vv[k]  = 0;
      m_err[k] = 0;
      prev     = m_brk[k];
      if (b == K_F0)      m_brk[k] = 1;
      else if (b != K_E0) m_brk[k] = 0;
      if (!en) begin
         m_entry[k] = 0;
         return;
      end
      if (prev || b == K_F0 || b == K_E0) return;
      d = digit_of(b);
      if (d >= 0) begin
         if (!m_entry[k]) begin
            m_num[k] = d; m_cnt[k] = 1; m_entry[k] = 1;
         end else if (m_cnt[k] < TB_DIGITS) begin
            m_num[k] = m_num[k] * 10 + d; m_cnt[k]++;
         end else begin
            m_err[k] = 1;
         end
      end else if (b == K_ENTER) begin
         if (m_entry[k]) begin
            if (m_num[k] >= min_of(k) && m_num[k] <= max_of(k)) begin
               m_val[k] = m_num[k]; m_vv[k] = 1; m_entry[k] = 0;
               if (k == 0) exp_q.push_back(10'(m_num[k]));
            end else begin
               m_err[k] = 1;
            end
         end
      end else if (b == K_BACK) begin
         if (m_entry[k]) begin
            m_num[k] = m_num[k] / 10; m_cnt[k]--;
            if (m_cnt[k] == 0) m_entry[k] = 0;
         end
      end else if (b == K_CLEAR) begin
         m_num[k] = 0; m_cnt[k] = 0; m_entry[k] = 0;
      end
   endtask

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every observed commit on dut0 must match the oldest expected one.
   task automatic score_commit();
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         check("sb_unexpected_commit", 32'(value0), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check("sb_commit_value", 32'(value0), 32'(e));
      end
   endtask

   task automatic check_outputs(input string where);
      check({where, " value0"}, 32'(value0), 32'(m_val[0]));
      check({where, " vv0"},    32'(vv0),    32'(m_vv[0]));
      check({where, " err0"},   32'(err0),   32'(m_err[0]));
      check({where, " bcd0"},   32'(bcd0),   bcd_of(m_num[0]));
      check({where, " cnt0"},   32'(cnt0),   32'(m_cnt[0]));
      check({where, " ed0"},    32'(ed0),    32'(m_entry[0]));
      check({where, " value1"}, 32'(value1), 32'(m_val[1]));
      check({where, " vv1"},    32'(vv1),    32'(m_vv[1]));
      check({where, " err1"},   32'(err1),   32'(m_err[1]));
      check({where, " bcd1"},   32'(bcd1),   bcd_of(m_num[1]));
      check({where, " cnt1"},   32'(cnt1),   32'(m_cnt[1]));
      check({where, " ed1"},    32'(ed1),    32'(m_entry[1]));
      check({where, " vv_err_excl"}, 32'(vv0 & err0 | vv1 & err1), 32'd0);
      if (vv0)  begin vv_seen[0]++; score_commit(); end
      if (vv1)  vv_seen[1]++;
      if (err0) err_seen[0]++;
      if (err1) err_seen[1]++;
   endtask

   // ---------------------------------------------------------------- drivers
   // One strobed byte; outputs are sampled on the following falling edge.
   task automatic send_byte(input logic [7:0] b, input logic en);
      @(negedge Clock);
      data    = b;
      data_en = 1'b1;
      Enable  = en;
      @(negedge Clock);
      data_en = 1'b0;
      model_step(0, b, en);
      model_step(1, b, en);
      check_outputs($sformatf("byte %02h en%0b", b, en));
   endtask

   // Make code followed by its F0-prefixed release.
   task automatic key(input logic [7:0] b, input logic en);
      send_byte(b, en);
      send_byte(K_F0, en);
      send_byte(b, en);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge Clock);
      for (int k = 0; k < 2; k++) begin
         m_vv[k] = 0; m_err[k] = 0;
         if (!Enable) m_entry[k] = 0;
      end
      check_outputs("idle");
   endtask

   task automatic pulse_reset(input string where);
      @(negedge Clock);
      nReset = 1'b0;
      #1;
      model_reset();
      check_outputs({where, " in_reset"});
      @(negedge Clock);
      nReset = 1'b1;
   endtask

   task automatic clear_counts();
      vv_seen  = '{0, 0};
      err_seen = '{0, 0};
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [7:0] b;
      logic       en;
      int         r;

      n_checks = 0;
      n_fail   = 0;
      clear_counts();
      nReset  = 1'b0;
      Enable  = 1'b0;
      data    = 8'h00;
      data_en = 1'b0;
      model_reset();
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check_outputs("reset");
      nReset = 1'b1;
      Enable = 1'b1;
      idle_cycles(2);

      // 1,2,3 ENTER
      clear_counts();
      key(code_of(1), 1'b1); key(code_of(2), 1'b1); key(code_of(3), 1'b1);
      key(K_ENTER, 1'b1);
      check("s123 value",   32'(value0), 32'd123);
      check("s123 vv_cnt",  32'(vv_seen[0]), 32'd1);
      check("s123 bcd",     32'(bcd0), 32'h123);
      check("s123 editing", 32'(ed0), 32'd0);
      check("s123 rng_err", 32'(err_seen[1]), 32'd1);

      // 4,5,6,7 overflows the three-digit buffer
      clear_counts();
      key(code_of(4), 1'b1); key(code_of(5), 1'b1); key(code_of(6), 1'b1);
      key(code_of(7), 1'b1);
      check("s4567 err_cnt", 32'(err_seen[0]), 32'd1);
      check("s4567 bcd",     32'(bcd0), 32'h456);
      check("s4567 count",   32'(cnt0), 32'd3);

      // 7,8, BS, BS returns to IDLE
      key(K_CLEAR, 1'b1);
      key(code_of(7), 1'b1); key(code_of(8), 1'b1);
      key(K_BACK, 1'b1); key(K_BACK, 1'b1);
      check("s78bb count", 32'(cnt0), 32'd0);
      check("s78bb ed",    32'(ed0), 32'd0);
      check("s78bb bcd",   32'(bcd0), 32'd0);
      check("s78bb value", 32'(value0), 32'd123);

      // 1,5,0 ENTER: out of range for the [5,99] instance
      clear_counts();
      key(K_CLEAR, 1'b1);
      key(code_of(1), 1'b1); key(code_of(5), 1'b1); key(code_of(0), 1'b1);
      key(K_ENTER, 1'b1);
      check("s150 err1",   32'(err_seen[1]), 32'd1);
      check("s150 value1", 32'(value1), 32'd5);
      check("s150 ed1",    32'(ed1), 32'd1);
      check("s150 value0", 32'(value0), 32'd150);

      // Stray release then 1: nothing entered; digit 9 with Enable low ignored
      key(K_CLEAR, 1'b1);
      send_byte(K_F0, 1'b1);
      send_byte(code_of(1), 1'b1);
      check("sbrk count", 32'(cnt0), 32'd0);
      key(code_of(9), 1'b0);
      check("sdis count", 32'(cnt0), 32'd0);
      idle_cycles(2);
      Enable = 1'b1;

      // Reset mid-entry
      clear_counts();
      key(code_of(4), 1'b1); key(code_of(2), 1'b1);
      pulse_reset("s42rst");
      check("s42rst count", 32'(cnt0), 32'd0);
      check("s42rst value", 32'(value0), 32'd0);
      check("s42rst vv",    32'(vv_seen[0]), 32'd0);
      idle_cycles(1);

      // Randomized traffic
      for (int n = 0; n < 700; n++) begin
         r = $urandom_range(0, 99);
         if (r < 50)      b = code_of($urandom_range(0, 9));
         else if (r < 62) b = K_ENTER;
         else if (r < 70) b = K_BACK;
         else if (r < 82) b = K_F0;
         else if (r < 85) b = K_CLEAR;
         else if (r < 88) b = K_E0;
         else             b = 8'($urandom_range(0, 255));
         en = ($urandom_range(0, 15) != 0);
         send_byte(b, en);
         if ($urandom_range(0, 31) == 0) idle_cycles($urandom_range(1, 3));
         if ($urandom_range(0, 199) == 0) pulse_reset("rand");
      end

      check("sb_pending", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/numeric_entry.md
NUMERIC_ENTRY -- requirements
Module: numeric_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 3, the maximum number of decimal digits held in the entry buffer (1..5).
REQ-002 SHALL have parameter VAL_W, default 10, the width of the committed binary value; VAL_W SHALL be able to hold MAX_VAL.
REQ-003 SHALL have parameter MIN_VAL, default 0, the lowest value accepted on commit.
REQ-004 SHALL have parameter MAX_VAL, default 999, the highest value accepted on commit; MIN_VAL <= MAX_VAL <= 10^DIGITS-1.
REQ-005 SHALL have port Clock, input, 1, the system clock, rising-edge active.
REQ-006 SHALL have port nReset, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port Enable, input, 1, which allows editing when high.
REQ-008 SHALL have port data, input, 8, the PS/2 scan-code byte.
REQ-009 SHALL have port data_en, input, 1, a one-cycle strobe marking data as valid.
REQ-010 SHALL have port Value, output, VAL_W, the last committed value (registered).
REQ-011 SHALL have port value_valid, output, 1, a one-cycle pulse on each successful commit.
REQ-012 SHALL have port err, output, 1, a one-cycle pulse on each rejected keystroke.
REQ-013 SHALL have port live_bcd, output, 4*DIGITS, the entry buffer as BCD with the least significant digit in bits [3:0].
REQ-014 SHALL have port count, output, 3, the number of digits currently entered (0..DIGITS).
REQ-015 SHALL have port editing, output, 1, which is high while the state machine is in ENTRY.

Function
REQ-016 SHALL recognise these make codes: digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46 (hex); ENTER=24; BACKSPACE=2D; CLEAR=15; RELEASE=F0; EXTEND=E0.
REQ-017 SHALL set a break flag on an F0 byte, and the next byte SHALL clear the flag and be otherwise ignored.
REQ-018 SHALL ignore E0 bytes and leave the break flag unchanged.
REQ-019 SHALL track the break flag on every data_en, regardless of Enable.
REQ-020 SHALL treat a keystroke as accepted only when data_en=1, Enable=1, the break flag=0, and data is not F0 or E0.
REQ-021 SHALL implement two states: IDLE (reset) and ENTRY.
REQ-022 SHALL, on an accepted digit in IDLE: clear the buffer, load the digit into position 0, set count=1, and go to ENTRY.
REQ-023 SHALL, on an accepted digit in ENTRY with count<DIGITS: shift the buffer up one digit, insert the new digit at position 0, and increment count.
REQ-024 SHALL, on an accepted digit in ENTRY with count=DIGITS: leave the buffer unchanged and pulse err.
REQ-025 SHALL, on BACKSPACE in ENTRY: shift the buffer down one digit, fill the top digit with 0, and decrement count; if count reaches 0, go to IDLE.
REQ-026 SHALL ignore BACKSPACE in IDLE.
REQ-027 SHALL, on CLEAR in any state: zero the buffer, set count=0, and go to IDLE; Value is unchanged.
REQ-028 SHALL compute the live binary value combinationally as the sum of digit(i)*10^i, at VAL_W bits, with no truncation for legal parameters.
REQ-029 SHALL, on ENTER in ENTRY with MIN_VAL <= live value <= MAX_VAL: load Value with the live value, pulse value_valid, and go to IDLE, keeping the buffer for display.
REQ-030 SHALL, on ENTER in ENTRY with the live value out of range: pulse err and leave Value, the buffer and the state unchanged.
REQ-031 SHALL ignore ENTER in IDLE (no value_valid pulse).
REQ-032 SHALL ignore all other accepted codes.
REQ-033 SHALL drive Value, value_valid, err and the buffer one cycle after the accepting data_en edge (latency 1).
REQ-034 SHALL, when Enable=0: force the state to IDLE on the next edge; hold the buffer, count and Value; and produce no pulses.
REQ-035 SHALL, when Enable returns high, restart entry only on a new digit.
REQ-036 SHALL never assert value_valid and err in the same cycle.

Reset
REQ-037 SHALL, while nReset=0, asynchronously set: state=IDLE, break flag=0, buffer=0, count=0, Value=MIN_VAL, value_valid=0, err=0.
REQ-038 SHALL discard any partial entry when reset is asserted mid-entry, leaving Value=MIN_VAL after release.

Verification
REQ-039 SHALL be verified with: keys 1,2,3 then ENTER (each followed by its F0-prefixed release) -> Value=123, one value_valid pulse, live_bcd=0x123, editing=0.
REQ-040 SHALL be verified with: 4,5,6,7 at DIGITS=3 -> err on the 4th digit, live_bcd=0x456, count=3.
REQ-041 SHALL be verified with: 7,8, BACKSPACE, BACKSPACE -> count=0, IDLE, live_bcd=0, Value unchanged.
REQ-042 SHALL be verified with: MAX_VAL=99, keys 1,5,0 then ENTER -> err pulse, Value held, state stays ENTRY.
REQ-043 SHALL be verified with: F0 then 16 -> no digit entered; and Enable=0 during digit 9 -> digit ignored.
REQ-044 SHALL be verified with: nReset pulsed after keys 4,2 -> count=0, Value=MIN_VAL, no value_valid pulse.
